// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter_if
// Brief    : Bundle of fetch, load/store and memory-side signals shared by
//            the RISC-V memory arbiter and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata
    );

    // Core and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Brief    : Two-requester (fetch / load-store) single-port memory arbiter.
//            One access outstanding at a time; grant -> busy -> response.
//            Default: data has fixed priority with a fetch starvation limit.
//            Macro ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    riscv_mem_arbiter_if.slave bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_IF = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    logic [1:0]  r_state_q,     w_state_d;
    logic        r_owner_d_q,   w_owner_d_d;   // 1: current access belongs to data port
    logic        r_store_q,     w_store_d;     // current data access is a store
    logic        r_if_gnt_q,    w_if_gnt_d;
    logic        r_d_gnt_q,     w_d_gnt_d;
    logic        r_if_rvalid_q, w_if_rvalid_d;
    logic        r_d_rvalid_q,  w_d_rvalid_d;
    logic [31:0] r_if_rdata_q,  w_if_rdata_d;
    logic [31:0] r_d_rdata_q,   w_d_rdata_d;
    logic        r_mem_en_q,    w_mem_en_d;
    logic        r_mem_rw_q,    w_mem_rw_d;
    logic [31:0] r_mem_addr_q,  w_mem_addr_d;
    logic [31:0] r_mem_wdata_q, w_mem_wdata_d;
    logic        w_pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic        r_last_d_q,    w_last_d_d;    // last owner, 0 = fetch

    // Alternate on contention: whoever did not own the port last time wins
    always_comb begin
        w_pick_d = bus.d_req && (!bus.if_req || !r_last_d_q);
    end
`else
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    logic [3:0]  r_starve_q,    w_starve_d;    // data grants made while fetch waited

    // Data wins unless fetch has waited through STARVE_MAX data grants
    always_comb begin
        w_pick_d = bus.d_req && (!bus.if_req || (r_starve_q != c_STARVE_MAX));
    end
`endif

    // Next-state logic: arbitration in IDLE, one busy cycle, then the response
    always_comb begin
        w_state_d     = r_state_q;
        w_owner_d_d   = r_owner_d_q;
        w_store_d     = r_store_q;
        w_if_gnt_d    = 1'b0;
        w_d_gnt_d     = 1'b0;
        w_if_rvalid_d = 1'b0;
        w_d_rvalid_d  = 1'b0;
        w_if_rdata_d  = r_if_rdata_q;
        w_d_rdata_d   = r_d_rdata_q;
        w_mem_en_d    = 1'b0;
        w_mem_rw_d    = 1'b0;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_d_d    = r_last_d_q;
`else
        w_starve_d    = r_starve_q;
`endif
        case (r_state_q)
            c_IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
                if (!bus.if_req) begin
                    w_starve_d = 4'd0;
                end
`endif
                if (bus.if_req || bus.d_req) begin
                    w_mem_en_d = 1'b1;
                    if (w_pick_d) begin
                        w_d_gnt_d    = 1'b1;
                        w_owner_d_d  = 1'b1;
                        w_store_d    = bus.d_we;
                        w_mem_rw_d   = bus.d_we;
                        w_mem_addr_d = bus.d_addr;
                        if (bus.d_we) begin
                            w_mem_wdata_d = bus.d_wdata;
                        end
                        w_state_d = c_BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
                        w_last_d_d = 1'b1;
`else
                        if (bus.if_req && (r_starve_q != c_STARVE_MAX)) begin
                            w_starve_d = r_starve_q + 4'd1;
                        end
`endif
                    end else begin
                        w_if_gnt_d   = 1'b1;
                        w_owner_d_d  = 1'b0;
                        w_store_d    = 1'b0;
                        w_mem_addr_d = bus.if_addr;
                        w_state_d    = c_BUSY_IF;
`ifdef ARB_ROUND_ROBIN_EN
                        w_last_d_d = 1'b0;
`else
                        w_starve_d = 4'd0;
`endif
                    end
                end
            end
            c_BUSY_IF, c_BUSY_D: begin
                w_state_d = c_RESP;
            end
            c_RESP: begin
                if (r_owner_d_q) begin
                    w_d_rvalid_d = 1'b1;
                    w_d_rdata_d  = r_store_q ? 32'd0 : bus.mem_rdata;
                end else begin
                    w_if_rvalid_d = 1'b1;
                    w_if_rdata_d  = bus.mem_rdata;
                end
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_IDLE;
            r_owner_d_q   <= 1'b0;
            r_store_q     <= 1'b0;
            r_if_gnt_q    <= 1'b0;
            r_d_gnt_q     <= 1'b0;
            r_if_rvalid_q <= 1'b0;
            r_d_rvalid_q  <= 1'b0;
            r_if_rdata_q  <= 32'd0;
            r_d_rdata_q   <= 32'd0;
            r_mem_en_q    <= 1'b0;
            r_mem_rw_q    <= 1'b0;
            r_mem_addr_q  <= 32'd0;
            r_mem_wdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d_q    <= 1'b0;
`else
            r_starve_q    <= 4'd0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_owner_d_q   <= w_owner_d_d;
            r_store_q     <= w_store_d;
            r_if_gnt_q    <= w_if_gnt_d;
            r_d_gnt_q     <= w_d_gnt_d;
            r_if_rvalid_q <= w_if_rvalid_d;
            r_d_rvalid_q  <= w_d_rvalid_d;
            r_if_rdata_q  <= w_if_rdata_d;
            r_d_rdata_q   <= w_d_rdata_d;
            r_mem_en_q    <= w_mem_en_d;
            r_mem_rw_q    <= w_mem_rw_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d_q    <= w_last_d_d;
`else
            r_starve_q    <= w_starve_d;
`endif
        end
    end

    assign bus.if_gnt    = r_if_gnt_q;
    assign bus.d_gnt     = r_d_gnt_q;
    assign bus.if_rvalid = r_if_rvalid_q;
    assign bus.d_rvalid  = r_d_rvalid_q;
    assign bus.if_rdata  = r_if_rdata_q;
    assign bus.d_rdata   = r_d_rdata_q;
    assign bus.mem_en    = r_mem_en_q;
    assign bus.mem_rw    = r_mem_rw_q;
    assign bus.mem_addr  = r_mem_addr_q;
    assign bus.mem_wdata = r_mem_wdata_q;
endmodule
`default_nettype wire
